pdm_modulator_mc: RTL and testbench
===================================

// Module: pdm_modulator_mc
//
// PURPOSE
// Multi-channel first-order sigma-delta PDM generator.
// - Shares one programmable prescaler and frame counter across CHANNELS outputs.
// - Each channel has a double-buffered setpoint, so pulse density changes only on frame boundaries.
// - Drives LED dimmers, audio DAC and heater outputs from a single system clock.
//
// PARAMETERS
// CHANNELS   4   number of independent PDM outputs (>=1)
// MOD_WIDTH  8   setpoint bitness; frame length = 2**MOD_WIDTH ticks
// DIV_WIDTH  16  prescaler bitness
//
// PORTS
// clk           in   1                   system clock
// rst           in   1                   asynchronous reset, active-high
// ena           in   1                   run enable
// div_setpoint  in   DIV_WIDTH           tick period = div_setpoint+1 clk cycles
// mod_setpoint  in   CHANNELS*MOD_WIDTH  packed setpoints; channel c = [c*MOD_WIDTH +: MOD_WIDTH]
// pdm_out       out  CHANNELS            PDM outputs, active HIGH, registered
// start_strobe  out  1                   one-clk pulse at each frame start
// busy          out  1                   modulator running
//
// BEHAVIOUR
// Reset:
// - rst high clears all state immediately.
// - pdm_out=0, start_strobe=0, busy=0; prescaler, frame_cnt, accumulators and shadows = 0.
// Prescaler:
// - While busy, counts 0..div_setpoint; at == div_setpoint the internal tick is high for 1 clk and the counter returns to 0.
// - Comparison is >= against the live div_setpoint, so lowering the value mid-count wraps on the next clk.
// - div_setpoint=0 gives a tick every clk.
// Frame:
// - frame_cnt (MOD_WIDTH bits) increments on each tick and wraps 2**MOD_WIDTH-1 -> 0.
// - start_strobe is registered: high for the 1 clk following a tick taken while frame_cnt==0.
// Shadow setpoints:
// - shadow_c <= mod_setpoint_c on the tick where frame_cnt==2**MOD_WIDTH-1.
// - Also loaded every clk while busy=0.
// - Mid-frame changes to mod_setpoint have no effect until the next frame.
// Modulator, per channel on each tick:
// - {carry, acc_c} = acc_c + shadow_c (MOD_WIDTH+1 bit sum).
// - pdm_out[c] <= carry; output is updated 1 clk after the tick.
// - pdm_out holds between ticks.
// - Density = shadow/2**MOD_WIDTH.
// - Ones per frame = shadow exactly, independent of the initial acc.
// - shadow=0 gives all-zero output; shadow=2**MOD_WIDTH-1 gives exactly one zero per frame.
// Enable:
// - ena 0->1: busy=1 on the next clk with prescaler=0 and frame_cnt=0.
// - The first tick occurs div_setpoint+1 clks after busy rises.
// - ena 1->0: on the next clk busy=0, pdm_out=0, start_strobe=0, and prescaler, frame_cnt and acc are cleared.
// - Mid-frame disable discards the partial frame.
// Simultaneous events:
// - A tick and the shadow load in the same clk: the accumulator uses the old shadow, the next tick uses the new one.
// - ena falling on a tick clk: disable wins, no output update.
//
// CONFIGURATION
// PDM_DITHER_EN defined:
// - A 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1, reset seed 16'hACE1) advances every tick.
// - On each tick with frame_cnt==0, acc_c is reloaded with LFSR rotated left by c, truncated to MOD_WIDTH bits, before the add.
// - Reload is skipped when MOD_WIDTH>16.
// - Pattern phase is randomised per frame; ones per frame is still exactly shadow.
// PDM_DITHER_EN undefined:
// - No LFSR; acc is continuous across frames and cleared only by rst or ena low.
// - The output pattern is fully periodic.
//
// TESTING
// 1. Reset: rst pulsed mid-run with CH0=8'h80 -> all outputs 0 within the same clk; busy=0; pdm_out stays 0 while rst is held.
// 2. Density: div=0, CH0..3 = 0, 1, 128, 255 -> per 256-tick frame, ones = 0, 1, 128, 255; CH2 toggles every tick.
// 3. Prescaler: div=3, ena rises -> busy next clk; ticks every 4 clks; start_strobe period 1024 clks.
//    - Lowering div from 9 to 2 at count 5 -> counter wraps the next clk.
// 4. Double buffer: mod_setpoint CH0 64->192 at tick 100 -> that frame has 64 ones, the next frame 192.
// 5. Enable: ena low at tick 50 -> next clk pdm_out=0, busy=0; ena high -> start_strobe after the first tick, pattern restarts from acc=0.
// 6. Dither build: random setpoints over 20 frames -> per-frame ones == shadow each frame, patterns differ between frames.

Source files
------------

// File: rtl/pdm_modulator_mc_if.sv
// Control/status bundle for the multi-channel PDM modulator.
// master: the controller driving enable and setpoints.
// slave:  the modulator itself.
interface pdm_modulator_mc_if #(
  parameter int CHANNELS  = 4,
  parameter int MOD_WIDTH = 8,
  parameter int DIV_WIDTH = 16
) ();
  logic                          ena;
  logic [DIV_WIDTH-1:0]          div_setpoint;
  logic [CHANNELS*MOD_WIDTH-1:0] mod_setpoint;
  logic [CHANNELS-1:0]           pdm_out;
  logic                          start_strobe;
  logic                          busy;

  modport master (
    output ena, div_setpoint, mod_setpoint,
    input  pdm_out, start_strobe, busy
  );

  modport slave (
    input  ena, div_setpoint, mod_setpoint,
    output pdm_out, start_strobe, busy
  );
endinterface

// File: rtl/pdm_modulator_mc.sv
// Multi-channel first-order sigma-delta PDM generator.
// One shared prescaler and frame counter; per-channel double-buffered
// setpoint and accumulator live in pdm_modulator_mc_lane.
// Optional build macro PDM_DITHER_EN: per-frame LFSR reload of the
// accumulators to randomise pattern phase (ones per frame unchanged).

module pdm_modulator_mc_lane #(
  parameter int MOD_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  input  logic                 tick,
  input  logic                 ld_shadow,
  input  logic                 reseed,
  input  logic [MOD_WIDTH-1:0] seed,
  input  logic [MOD_WIDTH-1:0] setpoint,
  output logic                 pdm
);
  logic [MOD_WIDTH-1:0] shadow, acc, acc_base;
  logic [MOD_WIDTH:0]   sum;

  assign acc_base = reseed ? seed : acc;
  assign sum      = {1'b0, acc_base} + {1'b0, shadow};

  // Shadow follows the live setpoint when idle, otherwise only at frame end.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            shadow <= '0;
    else if (ld_shadow) shadow <= setpoint;
  end

  // Accumulate on each tick; the carry is the PDM bit. Disable clears.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      pdm <= 1'b0;
    end else if (!run) begin
      acc <= '0;
      pdm <= 1'b0;
    end else if (tick) begin
      acc <= sum[MOD_WIDTH-1:0];
      pdm <= sum[MOD_WIDTH];
    end
  end
endmodule

module pdm_modulator_mc #(
  parameter int CHANNELS  = 4,
  parameter int MOD_WIDTH = 8,
  parameter int DIV_WIDTH = 16
) (
  input logic                  clk,
  input logic                  rst,
  pdm_modulator_mc_if.slave    bus
);
  localparam logic [MOD_WIDTH-1:0] FRAME_LAST = '1;

  logic                                busy_q, strobe_q;
  logic [DIV_WIDTH-1:0]                presc;
  logic [MOD_WIDTH-1:0]                frame_cnt;
  logic                                tick, frame_first, frame_last;
  logic                                ld_shadow, reseed;
  logic [CHANNELS-1:0]                 pdm;
  logic [CHANNELS-1:0][MOD_WIDTH-1:0]  seed;

  // ena low gates the tick so a falling enable always wins over output update.
  assign tick        = busy_q & bus.ena & (presc >= bus.div_setpoint);
  assign frame_first = (frame_cnt == '0);
  assign frame_last  = (frame_cnt == FRAME_LAST);
  assign ld_shadow   = ~busy_q | (tick & frame_last);

  assign bus.busy         = busy_q;
  assign bus.start_strobe = strobe_q;
  assign bus.pdm_out      = pdm;

  // Shared prescaler, frame counter and frame-start strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q    <= 1'b0;
      presc     <= '0;
      frame_cnt <= '0;
      strobe_q  <= 1'b0;
    end else begin
      busy_q <= bus.ena;
      if (!bus.ena || !busy_q) begin
        presc     <= '0;
        frame_cnt <= '0;
        strobe_q  <= 1'b0;
      end else begin
        presc    <= tick ? '0 : presc + DIV_WIDTH'(1);
        strobe_q <= tick & frame_first;
        if (tick) frame_cnt <= frame_cnt + MOD_WIDTH'(1);
      end
    end
  end

`ifdef PDM_DITHER_EN
  logic [15:0] lfsr;
  logic [31:0] lfsr_dbl;

  // x^16+x^14+x^13+x^11+1 Fibonacci LFSR, stepped once per tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       lfsr <= 16'hACE1;
    else if (tick) lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  assign lfsr_dbl = {lfsr, lfsr};
  assign reseed   = tick & frame_first & (MOD_WIDTH <= 16);

  for (genvar c = 0; c < CHANNELS; c++) begin : g_seed
    localparam int ROT = c % 16;
    if (MOD_WIDTH <= 16) begin : g_rot
      logic [15:0] rot;
      // Upper half of the doubled word is the LFSR rotated left by ROT.
      assign rot     = lfsr_dbl[31-ROT -: 16];
      assign seed[c] = rot[MOD_WIDTH-1:0];
    end else begin : g_none
      assign seed[c] = '0;
    end
  end
`else
  assign reseed = 1'b0;
  assign seed   = '0;
`endif

  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    pdm_modulator_mc_lane #(.MOD_WIDTH(MOD_WIDTH)) u_lane (
      .clk       (clk),
      .rst       (rst),
      .run       (bus.ena),
      .tick      (tick),
      .ld_shadow (ld_shadow),
      .reseed    (reseed),
      .seed      (seed[c]),
      .setpoint  (bus.mod_setpoint[c*MOD_WIDTH +: MOD_WIDTH]),
      .pdm       (pdm[c])
    );
  end
endmodule

// File: tb/tb_pdm_modulator_mc.sv
// Bench for pdm_modulator_mc (4 channels, 8-bit setpoints).
// Stimulus pushes per-frame expected high-cycle counts; a negedge monitor
// measures each complete strobe-to-strobe frame and pops/compares.
module tb_pdm_modulator_mc;
  logic clk, rst;
  int   checks = 0;
  int   failures = 0;

  typedef struct packed {
    logic [3:0][15:0] hi;
    logic [15:0]      len;
  } exp_t;
  exp_t exp_q[$];

  pdm_modulator_mc_if #(.CHANNELS(4), .MOD_WIDTH(8), .DIV_WIDTH(16)) ifc ();

  pdm_modulator_mc #(.CHANNELS(4), .MOD_WIDTH(8), .DIV_WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Each channel is high for setpoint*(div+1) cycles of a frame of 256*(div+1).
  task automatic push_frame(input logic [31:0] sp, input int div);
    exp_t e;
    for (int c = 0; c < 4; c++) e.hi[c] = 16'(int'(sp[c*8 +: 8]) * (div + 1));
    e.len = 16'(256 * (div + 1));
    exp_q.push_back(e);
  endtask

  task automatic wait_strobes(input int n, input int budget);
    int seen = 0;
    int k = 0;
    while (seen < n && k < budget) begin
      @(negedge clk);
      k++;
      if (ifc.start_strobe) seen++;
    end
    if (seen < n) check("strobe_timeout", seen, n);
  endtask

  task automatic wait_ch2_change(output int gap);
    logic prev;
    prev = ifc.pdm_out[2];
    gap = 0;
    for (int k = 1; k <= 60 && gap == 0; k++) begin
      @(negedge clk);
      if (ifc.pdm_out[2] != prev) gap = k;
    end
  endtask

  // Monitor: frame = cycles from one start_strobe up to the next.
  int mon_hi [4];
  int mon_cyc;
  bit in_frame = 0;
  always @(negedge clk) begin
    exp_t e;
    if (rst || !ifc.busy) begin
      in_frame = 0;
    end else begin
      if (ifc.start_strobe) begin
        if (in_frame) begin
          if (exp_q.size() == 0) begin
            check("frame_unexpected", 1, 0);
          end else begin
            e = exp_q.pop_front();
            for (int c = 0; c < 4; c++)
              check($sformatf("frame_ch%0d_high_cycles", c), mon_hi[c], int'(e.hi[c]));
            check("frame_len", mon_cyc, int'(e.len));
          end
        end
        in_frame = 1;
        mon_cyc = 0;
        for (int c = 0; c < 4; c++) mon_hi[c] = 0;
      end
      if (in_frame) begin
        mon_cyc++;
        for (int c = 0; c < 4; c++) mon_hi[c] += int'(ifc.pdm_out[c]);
      end
    end
  end

  initial begin
    int gap;
    rst = 1'b1;
    ifc.ena = 1'b0;
    ifc.div_setpoint = '0;
    ifc.mod_setpoint = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy", ifc.busy, 0);
    check("rst_pdm", ifc.pdm_out, 0);
    check("rst_strobe", ifc.start_strobe, 0);
    rst = 1'b0;

    // Density: CH0..3 = 0, 1, 128, 255 at div=0, two full frames
    @(negedge clk);
    push_frame(32'hFF80_0100, 0);
    push_frame(32'hFF80_0100, 0);
    ifc.mod_setpoint = 32'hFF80_0100;
    ifc.ena = 1'b1;
    wait_strobes(3, 1000);
    repeat (49) @(negedge clk);
    check("busy_running", ifc.busy, 1);
    ifc.ena = 1'b0;
    @(negedge clk);
    check("disable_busy", ifc.busy, 0);
    check("disable_pdm", ifc.pdm_out, 0);
    check("disable_strobe", ifc.start_strobe, 0);

    // Prescaler div=3: busy next clk, first strobe after first tick, 1024-clk frame
    push_frame(32'hFF80_0100, 3);
    ifc.div_setpoint = 16'd3;
    ifc.ena = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      if (i == 1) check("busy_after_ena", ifc.busy, 1);
      check($sformatf("strobe_latency_%0d", i), ifc.start_strobe, int'(i == 5));
    end
`ifndef PDM_DITHER_EN
    check("restart_tick1", ifc.pdm_out, 0);
    repeat (4) @(negedge clk);
    check("restart_tick2", ifc.pdm_out, 4'b1100);
`endif
    wait_strobes(1, 3000);
    repeat (10) @(negedge clk);
    ifc.ena = 1'b0;
    repeat (2) @(negedge clk);

    // Double buffer: setpoint changes mid-frame apply from the next frame
    ifc.div_setpoint = 16'd0;
    push_frame(32'h1E14_0A40, 0);
    push_frame(32'h1E14_0AC0, 0);
    push_frame(32'h0000_FF05, 0);
    ifc.mod_setpoint = 32'h1E14_0A40;
    ifc.ena = 1'b1;
    wait_strobes(1, 100);
    repeat (100) @(negedge clk);
    ifc.mod_setpoint = 32'h1E14_0AC0;
    wait_strobes(1, 1000);
    repeat (100) @(negedge clk);
    ifc.mod_setpoint = 32'h0000_FF05;
    wait_strobes(2, 1000);
    repeat (20) @(negedge clk);
    ifc.ena = 1'b0;
    repeat (2) @(negedge clk);

`ifndef PDM_DITHER_EN
    // Lower div 9 -> 2 while the prescaler sits at 5: wrap on the next clk
    ifc.mod_setpoint = 32'hFF80_0100;
    ifc.div_setpoint = 16'd9;
    ifc.ena = 1'b1;
    wait_ch2_change(gap);
    check("div9_first_toggle", gap, 21);
    gap = 0;
    for (int k = 1; k <= 20 && gap == 0; k++) begin
      @(negedge clk);
      if (ifc.pdm_out[2] != 1'b1) gap = k;
      else if (k == 5) ifc.div_setpoint = 16'd2;
    end
    check("div_lower_wrap_gap", gap, 6);
    wait_ch2_change(gap);
    check("div2_gap", gap, 3);
    ifc.ena = 1'b0;
    repeat (2) @(negedge clk);
`endif

    // Asynchronous reset mid-run with CH0=8'h80
    ifc.div_setpoint = 16'd0;
    ifc.mod_setpoint = 32'h0000_0080;
    ifc.ena = 1'b1;
    repeat (30) @(negedge clk);
    check("pre_rst_busy", ifc.busy, 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_pdm", ifc.pdm_out, 0);
    check("async_rst_busy", ifc.busy, 0);
    check("async_rst_strobe", ifc.start_strobe, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("rst_hold_pdm_%0d", i), ifc.pdm_out, 0);
    end
    ifc.ena = 1'b0;
    rst = 1'b0;
    repeat (3) @(negedge clk);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
